// File: rtl/countdown12.sv
// countdown12: 12-state mixed-radix down counter (hi 0..2, lo 0..3) with borrow pulse.
// Optional feature: define COUNTDOWN12_AUTORELOAD_EN to reload and keep counting at the terminal edge.
module countdown12 #(
   parameter logic [3:0] RELOAD_DEFAULT = 4'b1011
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] ld_val,
   input  logic       en,
   output logic [3:0] val,
   output logic       br,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [3:0] val_r;
   logic [3:0] val_s;
   logic [3:0] reload_r;
   logic [3:0] reload_s;
   logic       br_r;
   logic       br_s;
   logic       busy_r;
   logic       done_r;

   // A high digit of 3 is outside the encoding; clamp such loads to the top value.
   function automatic logic [3:0] sanitise(input logic [3:0] raw);
      logic [3:0] res;
      if (raw[3:2] == 2'b11) begin
         res = 4'b1011;
      end else begin
         res = raw;
      end
      return res;
   endfunction

   function automatic logic [3:0] decrement(input logic [3:0] cur);
      logic [3:0] res;
      if (cur[1:0] != 2'b00) begin
         res = {cur[3:2], cur[1:0] - 2'b01};
      end else begin
         res = {cur[3:2] - 2'b01, 2'b11};
      end
      return res;
   endfunction

   // Next-state, next-value and borrow decode; load overrides counting.
   always_comb begin
      state_s  = state_r;
      val_s    = val_r;
      reload_s = reload_r;
      br_s     = 1'b0;
      if (load) begin
         val_s    = sanitise(ld_val);
         reload_s = sanitise(ld_val);
         state_s  = ST_RUN;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_RUN: begin
               if (en) begin
                  if (val_r != 4'd0) begin
                     val_s = decrement(val_r);
                  end else begin
                     br_s = 1'b1;
`ifdef COUNTDOWN12_AUTORELOAD_EN
                     val_s   = reload_r;
                     state_s = ST_RUN;
`else
                     val_s   = 4'd0;
                     state_s = ST_DONE;
`endif
                  end
               end else begin
                  state_s = ST_RUN;
               end
            end
            ST_DONE: begin
               state_s = ST_DONE;
            end
            default: begin
               // Corrupted state: park in IDLE holding the last programmed start value.
               state_s = ST_IDLE;
               val_s   = reload_r;
            end
         endcase
      end
   end

   // State, value, reload and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         val_r    <= 4'd0;
         reload_r <= RELOAD_DEFAULT;
         br_r     <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         val_r    <= val_s;
         reload_r <= reload_s;
         br_r     <= br_s;
         busy_r   <= (state_s == ST_RUN);
         done_r   <= (state_s == ST_DONE);
      end
   end

   assign val  = val_r;
   assign br   = br_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_countdown12.sv
// Scoreboard bench for countdown12: integer reference model feeds an expectation queue,
// a monitor compares every cycle's outputs against it.
module tb_countdown12;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [3:0] ld_val;
   logic       en;
   logic [3:0] val;
   logic       br;
   logic       busy;
   logic       done;

   int checks;
   int errors;

   // expectation layout: {val[3:0], br, busy, done}
   logic [6:0] exp_q[$];

   // reference model state: 0 idle, 1 run, 2 done
   int m_state;
   int m_val;
   int m_reload;

   countdown12 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .ld_val (ld_val),
      .en     (en),
      .val    (val),
      .br     (br),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0t got val=%b br=%b busy=%b done=%b want val=%b br=%b busy=%b done=%b",
                  name, $time, got[6:3], got[2], got[1], got[0],
                  want[6:3], want[2], want[1], want[0]);
      end
   endtask

   function automatic logic [6:0] model_out(input int br_v);
      logic [3:0] v4;
      v4 = m_val[3:0];
      return {v4, (br_v != 0), (m_state == 1), (m_state == 2)};
   endfunction

   task automatic model_reset();
      m_state  = 0;
      m_val    = 0;
      m_reload = 11;
   endtask

   // one clock of stimulus: drive at negedge, advance model, queue the expected response
   task automatic cycle(input bit ld, input int ldv, input bit e);
      int b;
      @(negedge clk);
      load   = ld;
      ld_val = ldv[3:0];
      en     = e;
      b = 0;
      if (ld) begin
         m_val    = (ldv >= 12) ? 11 : ldv;
         m_reload = m_val;
         m_state  = 1;
      end else if (m_state == 1 && e) begin
         if (m_val > 0) begin
            m_val = m_val - 1;
         end else begin
            b = 1;
`ifdef COUNTDOWN12_AUTORELOAD_EN
            m_val = m_reload;
`else
            m_state = 2;
`endif
         end
      end
      exp_q.push_back(model_out(b));
   endtask

   // monitor: compare outputs shortly after each active edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         check("scoreboard", {val, br, busy, done}, exp_q.pop_front());
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      load   = 1'b0;
      ld_val = 4'd0;
      en     = 1'b0;
      model_reset();
      #2;
      check("reset_state", {val, br, busy, done}, 7'b0000_000);
      @(negedge clk);
      exp_q.push_back(model_out(0));
      @(negedge clk);
      rst_n = 1'b1;

      // EN alone from IDLE does nothing
      cycle(1'b0, 0, 1'b1);
      cycle(1'b0, 0, 1'b1);

      // full countdown from 11 plus a couple of trailing cycles
      cycle(1'b1, 11, 1'b0);
      for (int i = 0; i < 14; i++) cycle(1'b0, 0, 1'b1);

      // low-digit borrow 4 -> 3
      cycle(1'b1, 4, 1'b0);
      cycle(1'b0, 0, 1'b1);

      // load/EN priority at VAL=2
      cycle(1'b1, 2, 1'b0);
      cycle(1'b1, 8, 1'b1);
      cycle(1'b0, 0, 1'b0);

      // clamp of illegal high digit
      cycle(1'b1, 14, 1'b0);
      cycle(1'b1, 15, 1'b1);

      // load 0 then borrow; then pending borrow discarded by a load
      cycle(1'b1, 0, 1'b0);
      cycle(1'b0, 0, 1'b1);
      cycle(1'b1, 0, 1'b0);
      cycle(1'b1, 5, 1'b1);

      // autoreload pattern (also exercises DONE hold when the macro is off)
      cycle(1'b1, 1, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b1);

      // asynchronous reset mid-count at VAL=6
      cycle(1'b1, 6, 1'b0);
      cycle(1'b0, 0, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", {val, br, busy, done}, 7'b0000_000);
      model_reset();
      @(negedge clk);
      load = 1'b0;
      en   = 1'b1;
      exp_q.push_back(model_out(0));
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 0, 1'b1);
      cycle(1'b0, 0, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0));
      end

      cycle(1'b0, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
